// File: rtl/shift_counter_pkg.sv
// Shared encodings and helpers for the shift-sequence counter.
package shift_counter_pkg;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;
  localparam logic DIR_DOWN     = 1'b0;
  localparam logic DIR_UP       = 1'b1;

  function automatic int unsigned step_width(input int unsigned n);
    return $clog2(2 * n);
  endfunction

endpackage

// File: rtl/shift_seq_decode.sv
// Combinational legality check and step-index decode for ring / Johnson states.
module shift_seq_decode
  import shift_counter_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned SW = step_width(N)
) (
  input  logic [N-1:0]  out,
  input  logic          mode,
  output logic          illegal,
  output logic [SW-1:0] step,
  output logic          is_start
);

  int unsigned ones;
  int unsigned trans;
  int unsigned idx;

  always_comb begin
    ones  = $countones(out);
    trans = 0;
    idx   = 0;
    for (int unsigned i = 0; i + 1 < N; i++) begin
      if (out[i] != out[i+1]) trans++;
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (out[i]) idx = i;
    end

    illegal  = 1'b0;
    step     = '0;
    is_start = 1'b0;
    if (mode == MODE_RING) begin
      illegal  = (ones != 1);
      is_start = (out == N'(1));
      if (!illegal) step = SW'((N - idx) % N);
    end else begin
      // Legal Johnson states have at most one 0/1 boundary between adjacent bits.
      illegal  = (trans > 1);
      is_start = (out == '0);
      if (!illegal) step = out[0] ? SW'(2 * N - ones) : SW'(ones);
    end
  end

endmodule

// File: rtl/shift_sequence_counter.sv
// Run-time selectable ring / Johnson shift-sequence counter with load, direction,
// illegal-state self-correction, step decode and wrap pulse.
module shift_sequence_counter
  import shift_counter_pkg::*;
#(
  parameter int unsigned N            = 4,
  parameter bit          SELF_CORRECT = 1'b1,
  localparam int unsigned SW          = step_width(N)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic          dir,
  input  logic          mode,
  input  logic          load,
  input  logic [N-1:0]  load_val,
  output logic [N-1:0]  out,
  output logic [SW-1:0] step,
  output logic          illegal,
  output logic          wrap
);

  logic [N-1:0] out_d;
  logic [N-1:0] start_val;
  logic [N-1:0] shifted;
  logic         fb;
  logic         wrap_d;
  logic         unused_is_start;

  shift_seq_decode #(
    .N(N)
  ) u_decode (
    .out      (out),
    .mode     (mode),
    .illegal  (illegal),
    .step     (step),
    .is_start (unused_is_start)
  );

  assign start_val = (mode == MODE_JOHNSON) ? '0 : N'(1);

  always_comb begin
    fb      = '0;
    shifted = out;
    if (dir == DIR_UP) begin
      fb      = (mode == MODE_JOHNSON) ? ~out[N-1] : out[N-1];
      shifted = {out[N-2:0], fb};
    end else begin
      fb      = (mode == MODE_JOHNSON) ? ~out[0] : out[0];
      shifted = {fb, out[N-1:1]};
    end
  end

  always_comb begin
    out_d  = out;
    wrap_d = 1'b0;
    if (load) begin
      out_d = load_val;
    end else if (en) begin
      if (illegal && SELF_CORRECT) begin
        // Recovery jump to the start state is deliberately not reported as a wrap.
        out_d = start_val;
      end else begin
        out_d  = shifted;
        wrap_d = !illegal && (shifted == start_val);
      end
    end
  end

  // Reset value follows the mode input so either sequence starts cleanly.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out  <= start_val;
      wrap <= 1'b0;
    end else begin
      out  <= out_d;
      wrap <= wrap_d;
    end
  end

endmodule

// File: tb/tb_shift_sequence_counter.sv
// Directed self-checking bench: N=4 with and without self-correction, plus an N=8 Johnson run.
module tb_shift_sequence_counter;

  logic       clk;
  logic       rstn;
  logic       en, dir, mode, load;
  logic [3:0] load_val;
  logic [7:0] load_val8;

  logic [3:0] a_out, b_out;
  logic [2:0] a_step, b_step;
  logic       a_ill, b_ill, a_wrap, b_wrap;
  logic [7:0] c_out;
  logic [3:0] c_step;
  logic       c_ill, c_wrap;

  int n_total = 0;
  int n_fail  = 0;

  shift_sequence_counter #(.N(4), .SELF_CORRECT(1'b1)) dut_a (
    .clk(clk), .rstn(rstn), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(load_val), .out(a_out), .step(a_step), .illegal(a_ill), .wrap(a_wrap)
  );

  shift_sequence_counter #(.N(4), .SELF_CORRECT(1'b0)) dut_b (
    .clk(clk), .rstn(rstn), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(load_val), .out(b_out), .step(b_step), .illegal(b_ill), .wrap(b_wrap)
  );

  shift_sequence_counter #(.N(8), .SELF_CORRECT(1'b1)) dut_c (
    .clk(clk), .rstn(rstn), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(load_val8), .out(c_out), .step(c_step), .illegal(c_ill), .wrap(c_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       en, dir, mode, load;
    logic [3:0] load_val;
    logic [3:0] exp_out;
    int         exp_step;
    logic       exp_ill, exp_wrap;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string nm, input logic e, input logic d, input logic m,
                     input logic l, input logic [3:0] lv, input logic [3:0] eo,
                     input int es, input logic ei, input logic ew);
    vec_t v;
    v.name = nm; v.en = e; v.dir = d; v.mode = m; v.load = l; v.load_val = lv;
    v.exp_out = eo; v.exp_step = es; v.exp_ill = ei; v.exp_wrap = ew;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] johnson8(input int s);
    logic [7:0] ff;
    ff = 8'hFF;
    if (s == 0) return 8'h00;
    if (s <= 8) return ff << (8 - s);
    return ff >> (s - 8);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int wraps;
    rstn = 1'b1; en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0;
    load_val = '0; load_val8 = '0;

    // Reset in ring mode, then switch to Johnson while still held in reset.
    #1 rstn = 1'b0;
    #1;
    check("reset_ring_out", a_out, 4'b0001);
    check("reset_ring_step", a_step, 0);
    check("reset_ring_ill", a_ill, 0);
    check("reset_ring_wrap", a_wrap, 0);
    mode = 1'b1;
    tick();
    check("reset_johnson_out", a_out, 4'b0000);
    rstn = 1'b1;

    //   name          en dir mode ld  load_val  out      step ill wrap
    add("j_1000",      1, 0, 1, 0, 4'b0000, 4'b1000, 1, 0, 0);
    add("j_1100",      1, 0, 1, 0, 4'b0000, 4'b1100, 2, 0, 0);
    add("j_1110",      1, 0, 1, 0, 4'b0000, 4'b1110, 3, 0, 0);
    add("j_1111",      1, 0, 1, 0, 4'b0000, 4'b1111, 4, 0, 0);
    add("j_0111",      1, 0, 1, 0, 4'b0000, 4'b0111, 5, 0, 0);
    add("j_0011",      1, 0, 1, 0, 4'b0000, 4'b0011, 6, 0, 0);
    add("j_0001",      1, 0, 1, 0, 4'b0000, 4'b0001, 7, 0, 0);
    add("j_wrap",      1, 0, 1, 0, 4'b0000, 4'b0000, 0, 0, 1);
    add("r_load",      0, 1, 0, 1, 4'b0001, 4'b0001, 0, 0, 0);
    add("r_0010",      1, 1, 0, 0, 4'b0000, 4'b0010, 3, 0, 0);
    add("r_0100",      1, 1, 0, 0, 4'b0000, 4'b0100, 2, 0, 0);
    add("r_1000",      1, 1, 0, 0, 4'b0000, 4'b1000, 1, 0, 0);
    add("r_wrap",      1, 1, 0, 0, 4'b0000, 4'b0001, 0, 0, 1);
    add("r_hold1",     0, 1, 0, 0, 4'b0000, 4'b0001, 0, 0, 0);
    add("r_hold2",     0, 1, 0, 0, 4'b0000, 4'b0001, 0, 0, 0);
    add("r_hold3",     0, 1, 0, 0, 4'b0000, 4'b0001, 0, 0, 0);
    add("r_load_wins", 1, 0, 0, 1, 4'b0110, 4'b0110, 0, 1, 0);

    foreach (tbl[i]) begin
      en = tbl[i].en; dir = tbl[i].dir; mode = tbl[i].mode;
      load = tbl[i].load; load_val = tbl[i].load_val;
      tick();
      check({tbl[i].name, "_out"}, a_out, tbl[i].exp_out);
      check({tbl[i].name, "_step"}, a_step, tbl[i].exp_step);
      check({tbl[i].name, "_ill"}, a_ill, tbl[i].exp_ill);
      check({tbl[i].name, "_wrap"}, a_wrap, tbl[i].exp_wrap);
    end

    // Illegal Johnson load: corrected with SELF_CORRECT=1, shifted as-is with 0.
    en = 1'b0; dir = 1'b0; mode = 1'b1; load = 1'b1; load_val = 4'b1010;
    tick();
    check("ill_load_out", a_out, 4'b1010);
    check("ill_load_ill", a_ill, 1);
    check("ill_load_step", a_step, 0);
    check("ill_load_out_nc", b_out, 4'b1010);
    load = 1'b0; en = 1'b1;
    tick();
    check("correct_out", a_out, 4'b0000);
    check("correct_ill", a_ill, 0);
    check("correct_wrap", a_wrap, 0);
    check("nocorrect_out", b_out, 4'b1101);
    check("nocorrect_ill", b_ill, 1);
    check("nocorrect_wrap", b_wrap, 0);

    // Ring 0001 reinterpreted as Johnson, then advance to the Johnson start.
    en = 1'b0; mode = 1'b0; load = 1'b1; load_val = 4'b0001;
    tick();
    load = 1'b0;
    mode = 1'b1;
    #1;
    check("mode_flip_ill", a_ill, 0);
    check("mode_flip_step", a_step, 7);
    check("mode_flip_out", a_out, 4'b0001);
    en = 1'b1;
    tick();
    check("mode_flip_adv_out", a_out, 4'b0000);
    check("mode_flip_adv_wrap", a_wrap, 1);
    en = 1'b0;
    tick();
    check("wrap_one_cycle", a_wrap, 0);

    // Asynchronous reset mid-sequence.
    en = 1'b1;
    tick(); tick(); tick();
    check("pre_reset_out", a_out, 4'b1110);
    en = 1'b0;
    #2 rstn = 1'b0;
    #2;
    check("async_reset_out", a_out, 4'b0000);
    check("async_reset_wrap", a_wrap, 0);
    #2 rstn = 1'b1;
    en = 1'b1;
    tick();
    check("post_reset_out", a_out, 4'b1000);

    // N=8 Johnson: two full 16-step periods.
    en = 1'b0; load = 1'b0; mode = 1'b1; dir = 1'b0; load_val8 = '0;
    rstn = 1'b0;
    tick();
    check("n8_reset_out", c_out, 8'h00);
    rstn = 1'b1;
    en = 1'b1;
    wraps = 0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      check($sformatf("n8_out_%0d", k), c_out, johnson8(k % 16));
      check($sformatf("n8_step_%0d", k), c_step, k % 16);
      check($sformatf("n8_wrap_%0d", k), c_wrap, (k % 16) == 0);
      if (c_wrap) wraps++;
    end
    check("n8_wrap_count", wraps, 2);
    check("n8_ill", c_ill, 0);
    en = 1'b0;

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
